uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
Consumes the byte stream from uart_rx (o_Rx_DV/o_Rx_Byte) and parses framed image uploads.
- Frame format: sync byte, 16-bit pixel count (MSB first), N 8-bit pixel bytes, 8-bit checksum.
- Pixels are written sequentially into the frame-buffer RAM port starting at address 0.
- Reports completion or error to the image-processing control logic.

Parameters:
ADDR_W, 16, frame-buffer address width
MAX_PIXELS, 19200, largest accepted pixel count (160x120); must be <= 2**ADDR_W
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 8700, max idle clocks between bytes inside a frame (~10 byte times at 87 clks/bit)

Ports:
i_Clock  input  1  system clock
i_Reset  input  1  synchronous reset, active-high
i_Rx_DV  input  1  one-cycle strobe, byte valid (from uart_rx o_Rx_DV)
i_Rx_Byte  input  8  received byte (from uart_rx o_Rx_Byte)
o_Wr_En  output  1  frame-buffer write strobe, one cycle per pixel
o_Wr_Addr  output  ADDR_W  write address
o_Wr_Data  output  8  pixel byte
o_Busy  output  1  high in any state other than IDLE
o_Frame_Len  output  16  pixel count of current/last frame, latched at LEN_LO
o_Frame_Done  output  1  one-cycle pulse, frame accepted
o_Frame_Err  output  1  one-cycle pulse, frame aborted
o_Err_Code  output  2  0=none, 1=length>MAX_PIXELS, 2=checksum mismatch, 3=timeout

Behaviour:
- Reset (synchronous, checked every edge, overrides all inputs including i_Rx_DV):
  - State=IDLE.
  - All outputs 0.
  - Internal pixel counter, checksum accumulator and timeout counter cleared.
- All outputs are registered.
- States:
  - IDLE: DV with byte==SYNC_BYTE -> LEN_HI; o_Err_Code cleared to 0. Other bytes ignored silently.
  - LEN_HI: DV -> store high byte -> LEN_LO.
  - LEN_LO: DV -> form N and latch o_Frame_Len.
    - N > MAX_PIXELS -> pulse o_Frame_Err next cycle, o_Err_Code=1, go to IDLE.
    - N == 0 -> CSUM.
    - Otherwise -> PIXELS.
  - PIXELS: each DV produces one write.
    - o_Wr_En=1, o_Wr_Data=byte, o_Wr_Addr=pixel index (0..N-1), all on the cycle after DV (latency 1).
    - Accumulator += byte (mod 256).
    - DV for pixel N-1 -> CSUM.
  - CSUM: DV -> compare byte with accumulator.
    - Equal: o_Frame_Done pulse next cycle.
    - Not equal: o_Frame_Err pulse next cycle, o_Err_Code=2.
    - Either way -> IDLE.
- Pixels already written are not rolled back on any error.
- o_Wr_Addr holds its last value when o_Wr_En=0.
- Timeout:
  - Counter runs in every non-IDLE state and clears on each DV.
  - Reaching TIMEOUT_CLKS -> o_Frame_Err pulse, o_Err_Code=3, go to IDLE. The counter is cleared.
  - A DV arriving on the same cycle the counter reaches TIMEOUT_CLKS wins: the byte is processed and there is no timeout.
- A SYNC_BYTE value inside LEN/PIXELS/CSUM is treated as data, not a resync.
- o_Frame_Done and o_Frame_Err are never high together. Each is exactly one cycle.
- DV strobes are at least CLKS_PER_BIT*10 apart in normal use. The block must still accept back-to-back DV on consecutive cycles.
- Address counter width is ADDR_W and never wraps, guaranteed by the MAX_PIXELS check.

Optional Feature:
FRAME_LOADER_CHECKSUM_EN
- Defined: frame carries a trailing checksum byte; CSUM state and error code 2 exist as above.
- Undefined:
  - No checksum byte and no accumulator logic.
  - The DV of the last pixel goes to IDLE with an o_Frame_Done pulse one cycle after the final o_Wr_En.
  - N == 0 gives o_Frame_Done one cycle after LEN_LO.

Test Plan:
1. Checksum enabled. Send A5 00 04 10 20 30 40 A0 through uart_rx at 87 clks/bit.
   -> 4 writes: addr 0..3 with data 10, 20, 30, 40.
   -> o_Frame_Len=4, one o_Frame_Done, o_Err_Code=0, o_Busy falls after CSUM.
2. Send A5 00 02 01 02 FF.
   -> writes at addr 0 and 1, then o_Frame_Err pulse, o_Err_Code=2, no o_Frame_Done.
3. Send A5 4B 01 (N=19201).
   -> o_Frame_Err, o_Err_Code=1, no writes, IDLE.
   -> A following valid frame (test 1 bytes) completes normally and o_Err_Code returns to 0.
4. Send 00 FF 3F then test 1 bytes.
   -> leading bytes ignored with o_Busy=0, frame accepted.
5. Send A5 00 03 11, then idle 8700 clocks.
   -> o_Frame_Err exactly TIMEOUT_CLKS cycles after the 11 DV, o_Err_Code=3, one write only.
6. Assert i_Reset for one cycle midway through PIXELS of test 1.
   -> all outputs 0 next cycle, state IDLE.
   -> remaining bytes ignored until the next A5.
   -> A repeat of test 1 passes.
   -> With FRAME_LOADER_CHECKSUM_EN undefined, A5 00 02 07 08 gives o_Frame_Done with no checksum byte sent.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Parses framed image uploads (sync, 16-bit length, pixels[, checksum]) from uart_rx into frame-buffer writes.
// Define FRAME_LOADER_CHECKSUM_EN to expect a trailing mod-256 checksum byte after the pixels.
module uart_frame_loader #(
    parameter int          ADDR_W       = 16,
    parameter int          MAX_PIXELS   = 19200,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 8700
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [7:0]        o_Wr_Data,
    output logic              o_Busy,
    output logic [15:0]       o_Frame_Len,
    output logic              o_Frame_Done,
    output logic              o_Frame_Err,
    output logic [1:0]        o_Err_Code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PIXELS,
        S_CSUM
    } state_t;

    localparam int               TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic [15:0]         frame_len_q, frame_len_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic [1:0]          err_code_q, err_code_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`else
    logic                done_pend_q, done_pend_d;
`endif

    logic [15:0] len_n;
    logic        last_pix;

    assign len_n    = {len_hi_q, i_Rx_Byte};
    assign last_pix = ((32'(pix_cnt_q) + 32'd1) == {16'd0, frame_len_q});

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        pix_cnt_d    = pix_cnt_q;
        tmo_d        = '0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
`ifdef FRAME_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`else
        done_pend_d  = 1'b0;
        // Done trails the final write by one cycle when there is no checksum byte.
        frame_done_d = done_pend_q;
`endif

        // A byte arriving on the last idle cycle is processed instead of timing out.
        if (state_q != S_IDLE) begin
            if (i_Rx_DV) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd3;
                state_d     = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d    = S_LEN_HI;
                    err_code_d = 2'd0;
                    pix_cnt_d  = '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (i_Rx_DV) begin
                    len_hi_d = i_Rx_Byte;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (i_Rx_DV) begin
                    frame_len_d = len_n;
                    if ({16'd0, len_n} > 32'(MAX_PIXELS)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_IDLE;
                    end else if (len_n == 16'd0) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
                        state_d      = S_CSUM;
`else
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
`endif
                    end else begin
                        state_d = S_PIXELS;
                    end
                end
            end
            S_PIXELS: begin
                if (i_Rx_DV) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = i_Rx_Byte;
                    pix_cnt_d = pix_cnt_q + 1'b1;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    csum_d    = csum_q + i_Rx_Byte;
                    if (last_pix) begin
                        state_d = S_CSUM;
                    end
`else
                    if (last_pix) begin
                        done_pend_d = 1'b1;
                        state_d     = S_IDLE;
                    end
`endif
                end
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == csum_q) begin
                        frame_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            pix_cnt_q    <= '0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`else
            done_pend_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            pix_cnt_q    <= pix_cnt_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`else
            done_pend_q  <= done_pend_d;
`endif
        end
    end

    assign o_Wr_En      = wr_en_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Busy       = busy_q;
    assign o_Frame_Len  = frame_len_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Frame_Err  = frame_err_q;
    assign o_Err_Code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: table of frames plus hand sequences for timeout, reset and ignored bytes.
module tb_uart_frame_loader;

    localparam int         ADDR_W       = 16;
    localparam int         MAX_PIXELS   = 19200;
    localparam logic [7:0] SYNC         = 8'hA5;
    localparam int         TIMEOUT_CLKS = 8700;

    logic              clk = 1'b0;
    logic              rst;
    logic              dv;
    logic [7:0]        rx_byte;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic [15:0]       frame_len;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        err_code;

    uart_frame_loader #(
        .ADDR_W      (ADDR_W),
        .MAX_PIXELS  (MAX_PIXELS),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_DV     (dv),
        .i_Rx_Byte   (rx_byte),
        .o_Wr_En     (wr_en),
        .o_Wr_Addr   (wr_addr),
        .o_Wr_Data   (wr_data),
        .o_Busy      (busy),
        .o_Frame_Len (frame_len),
        .o_Frame_Done(frame_done),
        .o_Frame_Err (frame_err),
        .o_Err_Code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [15:0] len;
        logic        bad_csum;
        int          gap;
        int          seed;
        logic        exp_done;
        logic [1:0]  exp_code;
        int          exp_writes;
    } vec_t;

    wr_t  wq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   wr_cnt = 0;
    int   err_cyc = 0;
    int   last_dv_cyc = 0;
    logic [1:0] ev_code = '0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard for writes, pulse bookkeeping for done/err.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (wr_en) begin
                wr_cnt++;
                if (wq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, no write expected", wr_addr, wr_data);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (frame_done || frame_err) begin
                chk("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
                chk("pulse_one_cycle", 32'((frame_done & prev_done) | (frame_err & prev_err)), 32'd0);
                ev_code = err_code;
            end
            if (frame_done) done_cnt++;
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            prev_done = frame_done;
            prev_err  = frame_err;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Called on a negedge; DV is sampled by the following posedge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        dv          = 1'b1;
        rx_byte     = b;
        last_dv_cyc = cyc + 1;
        @(negedge clk);
        dv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pix(input int idx, input logic [7:0] b, input int gap);
        wq.push_back('{addr: 16'(idx), data: b});
        send_byte(b, gap);
    endtask

    function automatic logic [7:0] pix_val(input int seed, input int i);
        if (seed == 0) return 8'((i + 1) * 16);
        return 8'(i * 37 + seed);
    endfunction

    task automatic send_frame(input logic [15:0] len, input logic bad_csum, input int gap, input int seed);
        logic [7:0] cs;
        int npix;
        cs = 8'd0;
        npix = (int'(len) > MAX_PIXELS) ? 0 : int'(len);
        send_byte(SYNC, gap);
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        for (int i = 0; i < npix; i++) begin
            cs = cs + pix_val(seed, i);
            send_pix(i, pix_val(seed, i), gap);
        end
`ifdef FRAME_LOADER_CHECKSUM_EN
        if (int'(len) <= MAX_PIXELS) send_byte(bad_csum ? ~cs : cs, gap);
`else
        if (bad_csum) cs = ~cs;
`endif
    endtask

    task automatic wait_ev(input int d0, input int e0, input int budget);
        int k;
        k = 0;
        while ((done_cnt + err_cnt) == (d0 + e0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if ((done_cnt + err_cnt) == (d0 + e0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL event_wait: got no done/err pulse, expected one within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outcome(input int d0, input int e0, input int w0, input logic exp_done,
                                 input logic [1:0] exp_code, input int exp_writes, input logic [15:0] exp_len);
        chk("done_count", 32'(done_cnt - d0), exp_done ? 32'd1 : 32'd0);
        chk("err_count", 32'(err_cnt - e0), exp_done ? 32'd0 : 32'd1);
        chk("code_at_pulse", 32'(ev_code), 32'(exp_code));
        chk("err_code", 32'(err_code), 32'(exp_code));
        chk("frame_len", 32'(frame_len), 32'(exp_len));
        chk("write_count", 32'(wr_cnt - w0), 32'(exp_writes));
        chk("pending_writes", 32'(wq.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    vec_t vt[9];

    initial begin
        int d0, e0, w0;

        vt[0] = '{16'd4,     1'b0, 2, 0, 1'b1, 2'd0, 4};
`ifdef FRAME_LOADER_CHECKSUM_EN
        vt[1] = '{16'd4,     1'b1, 0, 7, 1'b0, 2'd2, 4};
`else
        vt[1] = '{16'd4,     1'b1, 0, 7, 1'b1, 2'd0, 4};
`endif
        vt[2] = '{16'd19201, 1'b0, 1, 0, 1'b0, 2'd1, 0};
        vt[3] = '{16'd4,     1'b0, 3, 0, 1'b1, 2'd0, 4};
        vt[4] = '{16'd0,     1'b0, 0, 0, 1'b1, 2'd0, 0};
        vt[5] = '{16'd1,     1'b0, 0, 9, 1'b1, 2'd0, 1};
        vt[6] = '{16'd65535, 1'b0, 0, 0, 1'b0, 2'd1, 0};
        vt[7] = '{16'd19200, 1'b0, 0, 3, 1'b1, 2'd0, 19200};
        vt[8] = '{16'd17,    1'b0, 1, 5, 1'b1, 2'd0, 17};

        rst = 1'b1;
        dv = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_len", 32'(frame_len), 32'd0);
        chk("rst_done_err", 32'({frame_done, frame_err}), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
            send_frame(vt[v].len, vt[v].bad_csum, vt[v].gap, vt[v].seed);
            wait_ev(d0, e0, 20);
            check_outcome(d0, e0, w0, vt[v].exp_done, vt[v].exp_code, vt[v].exp_writes, vt[v].len);
        end

        // Explicit bad-checksum frame (or checksum-free short frame).
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_byte(SYNC, 1);
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
`ifdef FRAME_LOADER_CHECKSUM_EN
        send_pix(0, 8'h01, 1);
        send_pix(1, 8'h02, 1);
        send_byte(8'hFF, 1);
        wait_ev(d0, e0, 20);
        check_outcome(d0, e0, w0, 1'b0, 2'd2, 2, 16'd2);
`else
        send_pix(0, 8'h07, 1);
        send_pix(1, 8'h08, 1);
        wait_ev(d0, e0, 20);
        check_outcome(d0, e0, w0, 1'b1, 2'd0, 2, 16'd2);
`endif

        // Leading garbage is ignored while idle.
        send_byte(8'h00, 1);
        chk("garbage_busy0", 32'(busy), 32'd0);
        send_byte(8'hFF, 1);
        chk("garbage_busy1", 32'(busy), 32'd0);
        send_byte(8'h3F, 1);
        chk("garbage_busy2", 32'(busy), 32'd0);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_frame(16'd4, 1'b0, 2, 0);
        wait_ev(d0, e0, 20);
        check_outcome(d0, e0, w0, 1'b1, 2'd0, 4, 16'd4);

        // Timeout after one pixel of a three-pixel frame.
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_byte(SYNC, 1);
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        send_pix(0, 8'h11, 0);
        wait_ev(d0, e0, TIMEOUT_CLKS + 20);
        chk("timeout_latency", 32'(err_cyc - last_dv_cyc), 32'(TIMEOUT_CLKS));
        check_outcome(d0, e0, w0, 1'b0, 2'd3, 1, 16'd3);

        // A byte on the last idle cycle beats the timeout.
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_byte(SYNC, 1);
        chk("sync_clears_code", 32'(err_code), 32'd0);
        send_byte(8'h00, 1);
        send_byte(8'h02, 1);
        send_pix(0, 8'h21, TIMEOUT_CLKS - 1);
        send_pix(1, 8'h43, 2);
`ifdef FRAME_LOADER_CHECKSUM_EN
        send_byte(8'h64, 2);
`endif
        wait_ev(d0, e0, 20);
        check_outcome(d0, e0, w0, 1'b1, 2'd0, 2, 16'd2);

        // Reset in the middle of the pixel phase.
        send_byte(SYNC, 1);
        chk("busy_in_frame", 32'(busy), 32'd1);
        send_byte(8'h00, 1);
        send_byte(8'h04, 1);
        send_pix(0, 8'h10, 2);
        send_pix(1, 8'h20, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", 32'(wr_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_len", 32'(frame_len), 32'd0);
        chk("midrst_flags", 32'({frame_done, frame_err, err_code}), 32'd0);
        w0 = wr_cnt;
        send_byte(8'h30, 1);
        send_byte(8'h40, 1);
        send_byte(8'hA0, 1);
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_writes", 32'(wr_cnt - w0), 32'd0);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_frame(16'd4, 1'b0, 2, 0);
        wait_ev(d0, e0, 20);
        check_outcome(d0, e0, w0, 1'b1, 2'd0, 4, 16'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
